// File: rtl/filte_sched.sv
// Round-robin scheduler that time-shares one FILTE datapath among NCH ADPCM channels.
// Each service takes IDLE -> LOAD -> WB, with YL state held here and written back from f_ylp.
module filte_sched #(
    parameter int NCH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req,
    input  logic [13*NCH-1:0] yup_bus,
    input  logic [NCH-1:0]    init,
    output logic [NCH-1:0]    ack,
    output logic [12:0]       f_yup,
    output logic [18:0]       f_yl,
    input  logic [18:0]       f_ylp,
    input  logic [2:0]        rd_sel,
    output logic [18:0]       yl_rd,
    output logic              busy
);

    localparam logic [18:0] YL_HOME = 19'h08800;
    localparam logic [3:0]  NCH_W   = 4'(NCH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WB
    } state_t;

    state_t      state;
    logic [2:0]  cur_ch;
    logic [2:0]  rr_ptr;
    logic [18:0] yl_q [8];
    logic [12:0] yup_arr [8];
    logic [7:0]  req_ext;
    logic [7:0]  init_ext;
    logic [7:0]  ack_onehot;
    logic        grant_any;
    logic [2:0]  grant_ch;
    logic [3:0]  sum;

    assign req_ext    = 8'(req);
    assign init_ext   = 8'(init);
    assign ack_onehot = 8'b1 << cur_ch;

    // Channels beyond NCH read as zero so the 3-bit channel ids can index freely.
    for (genvar g = 0; g < 8; g++) begin : g_yup
        if (g < NCH) begin : g_used
            assign yup_arr[g] = yup_bus[13*g +: 13];
        end else begin : g_unused
            assign yup_arr[g] = '0;
        end
    end

    // Scan from farthest to nearest so the channel right after rr_ptr wins last.
    always_comb begin
        grant_any = 1'b0;
        grant_ch  = '0;
        sum       = '0;
        for (int k = NCH; k >= 1; k--) begin
            sum = {1'b0, rr_ptr} + 4'(k);
            if (sum >= NCH_W) begin
                sum = sum - NCH_W;
            end
            if (req_ext[sum[2:0]]) begin
                grant_any = 1'b1;
                grant_ch  = sum[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ack    <= '0;
            busy   <= 1'b0;
            f_yup  <= '0;
            f_yl   <= YL_HOME;
            rr_ptr <= 3'(NCH - 1);
            cur_ch <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state  <= LOAD;
                        busy   <= 1'b1;
                        cur_ch <= grant_ch;
                        rr_ptr <= grant_ch;
                        f_yup  <= yup_arr[grant_ch];
                        f_yl   <= yl_q[grant_ch];
                    end
                end
                LOAD: begin
                    state <= WB;
                    ack   <= ack_onehot[NCH-1:0];
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Homing wins over a write-back landing on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 8; c++) begin
                yl_q[c] <= YL_HOME;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (init_ext[c]) begin
                    yl_q[c] <= YL_HOME;
                end else if (state == LOAD && cur_ch == 3'(c)) begin
                    yl_q[c] <= f_ylp;
                end
            end
        end
    end

    assign yl_rd = ({1'b0, rd_sel} < NCH_W) ? yl_q[rd_sel] : '0;

endmodule

// File: tb/tb_filte_sched.sv
// Directed bench for filte_sched; a unity-gain FILTE stand-in feeds f_ylp = YL + (YUP - YL>>6).
module tb_filte_sched;

    logic        test_clk;
    logic        reset;
    logic [3:0]  req;
    logic [51:0] yup_bus;
    logic [3:0]  init;
    logic [3:0]  ack;
    logic [12:0] f_yup;
    logic [18:0] f_yl;
    logic [18:0] f_ylp;
    logic [2:0]  rd_sel;
    logic [18:0] yl_rd;
    logic        busy;
    logic [12:0] dif;

    int n_checks = 0;
    int n_fail   = 0;
    int waited;

    filte_sched #(.NCH(4)) dut (
        .clk     (test_clk),
        .reset   (reset),
        .req     (req),
        .yup_bus (yup_bus),
        .init    (init),
        .ack     (ack),
        .f_yup   (f_yup),
        .f_yl    (f_yl),
        .f_ylp   (f_ylp),
        .rd_sel  (rd_sel),
        .yl_rd   (yl_rd),
        .busy    (busy)
    );

    always_comb begin
        dif   = f_yup - f_yl[18:6];
        f_ylp = f_yl + {{6{dif[12]}}, dif};
    end

    initial begin
        test_clk = 1'b0;
        forever #5 test_clk = ~test_clk;
    end

    task automatic tick();
        @(negedge test_clk);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input int ch, input logic [12:0] y);
        yup_bus[13*ch +: 13] = y;
        req = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b0;
        req     = '0;
        init    = '0;
        yup_bus = '0;
        rd_sel  = '0;

        repeat (3) tick();
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_ack", 32'(ack), 32'h0);
        checkOutput("rst_f_yup", 32'(f_yup), 32'h0);
        checkOutput("rst_f_yl", 32'(f_yl), 32'h08800);
        checkOutput("rst_yl0", 32'(yl_rd), 32'h08800);
        reset = 1'b1;

        // Channel 0, DIF = 0: YL stays home
        applyStimulus(4'b0001, 0, 13'h0220);
        tick();
        checkOutput("c0_load_busy", 32'(busy), 32'h1);
        checkOutput("c0_load_ack", 32'(ack), 32'h0);
        checkOutput("c0_f_yup", 32'(f_yup), 32'h0220);
        checkOutput("c0_f_yl", 32'(f_yl), 32'h08800);
        tick();
        checkOutput("c0_ack", 32'(ack), 32'h1);
        checkOutput("c0_yl", 32'(yl_rd), 32'h08800);
        req = '0;
        tick();
        checkOutput("c0_ack_drop", 32'(ack), 32'h0);
        checkOutput("c0_idle_busy", 32'(busy), 32'h0);

        // Channel 1, DIF = 0x40: YL moves to 0x08840
        applyStimulus(4'b0010, 1, 13'h0260);
        rd_sel = 3'd1;
        tick();
        checkOutput("c1_f_yup", 32'(f_yup), 32'h0260);
        checkOutput("c1_f_yl", 32'(f_yl), 32'h08800);
        checkOutput("c1_yl_before", 32'(yl_rd), 32'h08800);
        tick();
        checkOutput("c1_ack", 32'(ack), 32'h2);
        checkOutput("c1_yl", 32'(yl_rd), 32'h08840);
        req = '0;
        repeat (2) tick();
        checkOutput("c1_idle_hold_yup", 32'(f_yup), 32'h0260);
        checkOutput("c1_idle_hold_yl", 32'(f_yl), 32'h08800);
        rd_sel = 3'd5;
        #1;
        checkOutput("rd_out_of_range", 32'(yl_rd), 32'h0);

        // Re-home everything, then hold all four requests: 0,1,2,3,0 every 3 cycles
        reset = 1'b0;
        tick();
        reset = 1'b1;
        rd_sel = 3'd1;
        #1;
        checkOutput("rst_yl1", 32'(yl_rd), 32'h08800);
        yup_bus = {4{13'h0220}};
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            waited = 0;
            do begin
                tick();
                waited++;
            end while (ack == 4'b0 && waited < 8);
            checkOutput($sformatf("rr_ack_%0d", n), 32'(ack), 32'h1 << (n % 4));
            checkOutput($sformatf("rr_gap_%0d", n), 32'(waited), (n == 0) ? 32'd2 : 32'd3);
        end
        req = '0;
        repeat (2) tick();
        checkOutput("rr_idle_busy", 32'(busy), 32'h0);

        // Homing channel 2 on its write-back edge wins, ack still issued
        applyStimulus(4'b0100, 2, 13'h0260);
        rd_sel = 3'd2;
        tick();
        checkOutput("c2_f_yup", 32'(f_yup), 32'h0260);
        init = 4'b0100;
        tick();
        init = '0;
        checkOutput("c2_ack", 32'(ack), 32'h4);
        checkOutput("c2_yl_homed", 32'(yl_rd), 32'h08800);
        req = '0;
        repeat (2) tick();

        // Reset during LOAD of channel 3 abandons the operation
        applyStimulus(4'b1000, 3, 13'h0260);
        rd_sel = 3'd3;
        tick();
        checkOutput("c3_load_busy", 32'(busy), 32'h1);
        checkOutput("c3_f_yup", 32'(f_yup), 32'h0260);
        reset = 1'b0;
        req   = '0;
        #1;
        checkOutput("c3_rst_busy", 32'(busy), 32'h0);
        checkOutput("c3_rst_ack", 32'(ack), 32'h0);
        checkOutput("c3_rst_f_yup", 32'(f_yup), 32'h0);
        tick();
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checkOutput($sformatf("c3_no_ack_%0d", n), 32'(ack), 32'h0);
        end
        checkOutput("c3_yl", 32'(yl_rd), 32'h08800);
        checkOutput("c3_idle_busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
